// File: rtl/dcache_wb.sv
// Direct-mapped write-back/write-allocate data cache with a word-beat miss FSM.
// Optional event counters are compiled in with `define DCACHE_STATS_EN.
module dcache_wb #(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 16,
  parameter int LINES      = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [31:0]       stat_hits,
  output logic [31:0]       stat_misses,
  output logic [31:0]       stat_wbacks
);
  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam int ARR_W = IDX_W + OFF_W;

  typedef enum logic [2:0] {S_IDLE, S_COMPARE, S_WRITEBACK, S_REFILL, S_RESP} state_t;

  state_t             state, state_n;
  logic [OFF_W-1:0]   beat, beat_n;
  logic               req_we_q;
  logic [ADDR_W-1:0]  req_addr_q;
  logic [DATA_W-1:0]  req_wdata_q;

  logic [DATA_W-1:0]  data_arr [LINES*LINE_WORDS];
  logic [TAG_W-1:0]   tag_arr  [LINES];
  logic [LINES-1:0]   valid_q, dirty_q;

  logic [TAG_W-1:0]   req_tag, old_tag;
  logic [IDX_W-1:0]   req_idx;
  logic [OFF_W-1:0]   req_off;
  logic               hit, last_beat, beat_fire, wb_last, refill_last;
  logic               wr_en;
  logic [ARR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]  wr_data;

  assign req_tag     = req_addr_q[ADDR_W-1 -: TAG_W];
  assign req_idx     = req_addr_q[OFF_W +: IDX_W];
  assign req_off     = req_addr_q[OFF_W-1:0];
  assign old_tag     = tag_arr[req_idx];
  assign hit         = valid_q[req_idx] && (old_tag == req_tag);
  assign last_beat   = &beat;
  assign beat_fire   = mem_valid && mem_ready;
  assign wb_last     = (state == S_WRITEBACK) && beat_fire && last_beat;
  assign refill_last = (state == S_REFILL) && beat_fire && last_beat;

  always_comb begin
    state_n = state;
    beat_n  = beat;
    wr_en   = 1'b0;
    wr_addr = {req_idx, req_off};
    wr_data = req_wdata_q;
    case (state)
      S_IDLE:
        if (req_valid && req_ready) state_n = S_COMPARE;
      S_COMPARE:
        if (hit) begin
          state_n = S_RESP;
          wr_en   = req_we_q;
        end else begin
          beat_n  = '0;
          state_n = dirty_q[req_idx] ? S_WRITEBACK : S_REFILL;
        end
      S_WRITEBACK:
        if (beat_fire) begin
          beat_n = beat + 1'b1;
          if (last_beat) state_n = S_REFILL;
        end
      S_REFILL:
        if (beat_fire) begin
          wr_en   = 1'b1;
          wr_addr = {req_idx, beat};
          wr_data = mem_rdata;
          beat_n  = beat + 1'b1;
          if (last_beat) state_n = S_COMPARE;
        end
      S_RESP:
        state_n = S_IDLE;
      default:
        state_n = S_IDLE;
    endcase
  end

  // Control state and registered outputs; mem_* are computed from the next beat
  // so they hold steady while mem_ready is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      beat       <= '0;
      valid_q    <= '0;
      dirty_q    <= '0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      mem_valid  <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      state      <= state_n;
      beat       <= beat_n;
      req_ready  <= (state_n == S_IDLE);
      resp_valid <= (state_n == S_RESP);
      mem_valid  <= (state_n == S_WRITEBACK) || (state_n == S_REFILL);
      mem_we     <= (state_n == S_WRITEBACK);
      if (state_n == S_WRITEBACK) begin
        mem_addr  <= {old_tag, req_idx, beat_n};
        mem_wdata <= data_arr[{req_idx, beat_n}];
      end else if (state_n == S_REFILL) begin
        mem_addr  <= {req_tag, req_idx, beat_n};
      end
      if (state == S_COMPARE && hit) begin
        resp_rdata <= req_we_q ? req_wdata_q : data_arr[{req_idx, req_off}];
        if (req_we_q) dirty_q[req_idx] <= 1'b1;
      end
      if (wb_last) dirty_q[req_idx] <= 1'b0;
      if (refill_last) begin
        valid_q[req_idx] <= 1'b1;
        dirty_q[req_idx] <= 1'b0;
      end
    end
  end

  // Storage arrays and request latch carry no reset.
  always_ff @(posedge clk) begin
    if (wr_en) data_arr[wr_addr] <= wr_data;
    if (refill_last) tag_arr[req_idx] <= req_tag;
    if (req_valid && req_ready) begin
      req_we_q    <= req_we;
      req_addr_q  <= req_addr;
      req_wdata_q <= req_wdata;
    end
  end

`ifdef DCACHE_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  logic [31:0] hits_q, misses_q, wbacks_q;
  logic        recompare_q;

  // recompare_q marks the guaranteed-hit COMPARE that follows a refill.
  always_ff @(posedge clk) begin
    if (rst) begin
      hits_q      <= '0;
      misses_q    <= '0;
      wbacks_q    <= '0;
      recompare_q <= 1'b0;
    end else begin
      recompare_q <= refill_last;
      if (state == S_COMPARE && hit && !recompare_q) hits_q <= sat_inc(hits_q);
      if (state == S_COMPARE && !hit) misses_q <= sat_inc(misses_q);
      if (wb_last) wbacks_q <= sat_inc(wbacks_q);
    end
  end

  assign stat_hits   = hits_q;
  assign stat_misses = misses_q;
  assign stat_wbacks = wbacks_q;
`else
  assign stat_hits   = '0;
  assign stat_misses = '0;
  assign stat_wbacks = '0;
`endif
endmodule

// File: tb/tb_dcache_wb.sv
// Bench for dcache_wb: table of requests against a word-addressed memory model,
// plus stall and mid-refill reset sequences.
module tb_dcache_wb;
  localparam int ADDR_W = 17;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid, req_ready, req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              mem_valid, mem_ready, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic [31:0]       stat_hits, stat_misses, stat_wbacks;

  always #5 clk = ~clk;

  dcache_wb dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .stat_hits(stat_hits), .stat_misses(stat_misses), .stat_wbacks(stat_wbacks)
  );

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  assign mem_rdata = mem[mem_addr];

  int n_checks = 0;
  int n_fail   = 0;
  int stall_checks = 0;
  logic toggle_en = 1'b0;

  logic [ADDR_W-1:0] wb_addr_q[$];
  logic [DATA_W-1:0] wb_data_q[$];
  logic [ADDR_W-1:0] rf_addr_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory slave: logs beats, performs writebacks, checks stall stability.
  logic              stall_prev = 1'b0;
  logic [ADDR_W-1:0] stall_addr;
  logic              stall_we;
  logic [DATA_W-1:0] stall_wdata;
  always @(posedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        stall_checks++;
        check("stall_hold", {mem_valid, mem_we, mem_addr, mem_wdata},
              {1'b1, stall_we, stall_addr, stall_wdata});
      end
      if (mem_valid && mem_ready) begin
        if (mem_we) begin
          wb_addr_q.push_back(mem_addr);
          wb_data_q.push_back(mem_wdata);
          mem[mem_addr] = mem_wdata;
        end else begin
          rf_addr_q.push_back(mem_addr);
        end
      end
      stall_prev  = mem_valid && !mem_ready;
      stall_addr  = mem_addr;
      stall_we    = mem_we;
      stall_wdata = mem_wdata;
    end
  end

  always @(negedge clk) if (toggle_en) mem_ready = ~mem_ready;

  task automatic do_req(input logic we, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] wd,
                        output logic [DATA_W-1:0] rdata, output int lat);
    int w;
    @(negedge clk);
    wb_addr_q.delete(); wb_data_q.delete(); rf_addr_q.delete();
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
    w = 0;
    while (!req_ready && w < 50) begin @(negedge clk); w++; end
    if (!req_ready) begin
      check("accept_timeout", 0, 1);
      req_valid = 1'b0; rdata = '0; lat = -1;
      return;
    end
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 300) begin @(negedge clk); lat++; end
    if (!resp_valid) begin
      check("resp_timeout", 0, 1);
      rdata = '0;
      return;
    end
    rdata = resp_rdata;
    @(negedge clk);
    check("resp_pulse", resp_valid, 0);
  endtask

  task automatic check_stats(input int h, input int m, input int wb);
`ifdef DCACHE_STATS_EN
    check("stat_hits", stat_hits, h);
    check("stat_misses", stat_misses, m);
    check("stat_wbacks", stat_wbacks, wb);
`else
    check("stat_hits_tied", stat_hits, 0);
    check("stat_misses_tied", stat_misses, 0);
    check("stat_wbacks_tied", stat_wbacks, 0);
`endif
  endtask

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] exp_rdata;
    int                exp_lat;
    int                exp_wb;
    int                exp_rf;
    logic [ADDR_W-1:0] wb_base;
    logic [ADDR_W-1:0] rf_base;
    logic [DATA_W-1:0] exp_wb2;
  } vec_t;

  vec_t tv[10];

  task automatic run_vec(input int i);
    logic [DATA_W-1:0] rd;
    int lat;
    do_req(tv[i].we, tv[i].addr, tv[i].wdata, rd, lat);
    check($sformatf("v%0d_rdata", i), rd, tv[i].exp_rdata);
    check($sformatf("v%0d_latency", i), lat, tv[i].exp_lat);
    check($sformatf("v%0d_wb_beats", i), wb_addr_q.size(), tv[i].exp_wb);
    check($sformatf("v%0d_rf_beats", i), rf_addr_q.size(), tv[i].exp_rf);
    if (tv[i].exp_wb == 16 && wb_addr_q.size() == 16) begin
      check($sformatf("v%0d_wb_addr0", i), wb_addr_q[0], tv[i].wb_base);
      check($sformatf("v%0d_wb_addr15", i), wb_addr_q[15], tv[i].wb_base + 17'd15);
      check($sformatf("v%0d_wb_word2", i), wb_data_q[2], tv[i].exp_wb2);
    end
    if (tv[i].exp_rf == 16 && rf_addr_q.size() == 16) begin
      check($sformatf("v%0d_rf_addr0", i), rf_addr_q[0], tv[i].rf_base);
      check($sformatf("v%0d_rf_addr15", i), rf_addr_q[15], tv[i].rf_base + 17'd15);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] rd;
    int lat, w;
    logic saw_resp;

    //             we    addr         wdata          rdata          lat wb rf wb_base      rf_base      wb2
    tv[0] = '{1'b0, 17'h00010, 32'h0,        32'h0000_1010, 19, 0, 16, 17'h0,      17'h00010, 32'h0};
    tv[1] = '{1'b0, 17'h00013, 32'h0,        32'h0000_1013,  2, 0,  0, 17'h0,      17'h0,     32'h0};
    tv[2] = '{1'b1, 17'h00012, 32'hDEADBEEF, 32'hDEADBEEF,   2, 0,  0, 17'h0,      17'h0,     32'h0};
    tv[3] = '{1'b0, 17'h04012, 32'h0,        32'h0000_5012, 35,16, 16, 17'h00010, 17'h04010, 32'hDEADBEEF};
    tv[4] = '{1'b0, 17'h00012, 32'h0,        32'hDEADBEEF,  19, 0, 16, 17'h0,      17'h00010, 32'h0};
    tv[5] = '{1'b1, 17'h00025, 32'hCAFEF00D, 32'hCAFEF00D,  19, 0, 16, 17'h0,      17'h00020, 32'h0};
    tv[6] = '{1'b0, 17'h00025, 32'h0,        32'hCAFEF00D,   2, 0,  0, 17'h0,      17'h0,     32'h0};
    tv[7] = '{1'b0, 17'h00020, 32'h0,        32'h0000_1020,  2, 0,  0, 17'h0,      17'h0,     32'h0};
    tv[8] = '{1'b0, 17'h14025, 32'h0,        32'h0001_5025, 35,16, 16, 17'h00020, 17'h14020, 32'h0000_1022};
    tv[9] = '{1'b0, 17'h00025, 32'h0,        32'hCAFEF00D,  19, 0, 16, 17'h0,      17'h00020, 32'h0};

    for (int a = 0; a < (1 << ADDR_W); a++) mem[a] = 32'h1000 + a;

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_mem_outputs", {mem_valid, mem_we, mem_addr, mem_wdata}, 0);
    check_stats(0, 0, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_req_ready", req_ready, 1);

    for (int i = 0; i < 2; i++) run_vec(i);
    check_stats(1, 1, 0);
    for (int i = 2; i < 10; i++) run_vec(i);
    check_stats(4, 6, 2);
    check("mem_store_preserved", mem[17'h00012], 32'hDEADBEEF);

    // Refill with mem_ready alternating every cycle.
    @(posedge clk); #1;
    toggle_en = 1'b1; mem_ready = 1'b1;
    do_req(1'b0, 17'h00180, '0, rd, lat);
    @(posedge clk); #1;
    toggle_en = 1'b0; mem_ready = 1'b1;
    check("stall_rdata", rd, 32'h0000_1180);
    check("stall_rf_beats", rf_addr_q.size(), 16);
    if (rf_addr_q.size() == 16) check("stall_rf_last", rf_addr_q[15], 17'h0018F);
    check("stall_seen", stall_checks > 0, 1);
    do_req(1'b0, 17'h00187, '0, rd, lat);
    check("stall_hit_rdata", rd, 32'h0000_1187);
    check("stall_hit_latency", lat, 2);
    check_stats(5, 7, 2);

    // Reset while beat 7 of a refill is on the bus.
    @(negedge clk);
    rf_addr_q.delete();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 17'h00300;
    w = 0;
    while (!req_ready && w < 50) begin @(negedge clk); w++; end
    @(negedge clk);
    req_valid = 1'b0;
    w = 0;
    while (rf_addr_q.size() < 7 && w < 100) begin @(negedge clk); w++; end
    check("abort_reach_beat7", rf_addr_q.size(), 7);
    check("abort_addr_beat7", mem_addr, 17'h00307);
    rst = 1'b1;
    @(negedge clk);
    check("abort_mem_valid", mem_valid, 0);
    check("abort_resp_valid", resp_valid, 0);
    check("abort_req_ready", req_ready, 0);
    rst = 1'b0;
    saw_resp = 1'b0;
    repeat (5) begin @(negedge clk); if (resp_valid || mem_valid) saw_resp = 1'b1; end
    check("abort_quiet", saw_resp, 0);
    check_stats(0, 0, 0);
    do_req(1'b0, 17'h00300, '0, rd, lat);
    check("reissue_rdata", rd, 32'h0000_1300);
    check("reissue_latency", lat, 19);
    check("reissue_rf_beats", rf_addr_q.size(), 16);
    do_req(1'b0, 17'h00010, '0, rd, lat);
    check("valid_cleared_latency", lat, 19);
    check("valid_cleared_rdata", rd, 32'h0000_1010);
    check_stats(0, 2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
